// File: rtl/spram_pkg.sv
// Shared types and helpers for the spram bus controller.
package spram_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      SERVE = 1'b1
   } spram_ctrl_state_e;

   // Widest byte-enable vector be2bwm accepts; callers zero-extend and slice the result.
   localparam int BWM_MAX_BE = 64;

   function automatic logic [BWM_MAX_BE*8-1:0] be2bwm(input logic [BWM_MAX_BE-1:0] be);
      logic [BWM_MAX_BE*8-1:0] m;
      m = '0;
      for (int k = 0; k < BWM_MAX_BE; k++) begin
         m[8*k +: 8] = {8{be[k]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/spram_bus_ctrl.sv
// Req/gnt bus front end for a single-port byte-masked SRAM, with a clear engine
// that zeroes the whole array after reset or on request.
module spram_bus_ctrl
   import spram_pkg::*;
#(
   parameter int DEPTH          = 1024,
   parameter int WIDTH          = 32,
   parameter bit CLEAR_ON_RESET = 1'b1,
   localparam int DEPTH_W       = $clog2(DEPTH),
   localparam int BE_W          = WIDTH / 8,
   localparam int OFF_W         = $clog2(BE_W)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               req_i,
   output logic               gnt_o,
   input  logic               we_i,
   input  logic [BE_W-1:0]    be_i,
   input  logic [31:0]        addr_i,
   input  logic [WIDTH-1:0]   wdata_i,
   output logic               rvalid_o,
   output logic [WIDTH-1:0]   rdata_o,
   input  logic               clear_i,
   output logic               init_done_o,
   output logic               ram_ce,
   output logic               ram_we,
   output logic [WIDTH-1:0]   ram_bwm,
   output logic [WIDTH-1:0]   ram_d,
   output logic [DEPTH_W-1:0] ram_a,
   input  logic [WIDTH-1:0]   ram_q
);

   localparam logic [31:0]        ADDR_USED = ((32'd1 << DEPTH_W) - 32'd1) << OFF_W;
   localparam logic [DEPTH_W-1:0] LAST_IDX  = DEPTH_W'(DEPTH - 1);

   spram_ctrl_state_e            state_q, state_d;
   logic [DEPTH_W-1:0]           cnt_q, cnt_d;
   logic                         rvalid_q;
   logic                         gnt;
   logic [DEPTH_W-1:0]           word_idx;
   logic [BWM_MAX_BE-1:0]        be_ext;
   logic [BWM_MAX_BE*8-1:0]      bwm_full;
   logic                         unused_sig;

   assign word_idx   = addr_i[OFF_W+DEPTH_W-1:OFF_W];
   assign be_ext     = BWM_MAX_BE'(be_i);
   assign bwm_full   = be2bwm(be_ext);
   // Aliased upper address bits and byte-offset bits are deliberately ignored.
   assign unused_sig = ^{addr_i & ~ADDR_USED, bwm_full};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      ram_ce  = 1'b0;
      ram_we  = 1'b0;
      ram_bwm = '0;
      ram_d   = '0;
      ram_a   = '0;
      // Everything stays idle while reset is held so no stray access or grant escapes.
      if (!RST) begin
         case (state_q)
            CLEAR: begin
               ram_ce  = 1'b1;
               ram_we  = 1'b1;
               ram_bwm = '1;
               ram_a   = cnt_q;
               if (cnt_q == LAST_IDX) begin
                  state_d = SERVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            SERVE: begin
               if (clear_i) begin
                  state_d = CLEAR;
               end else if (req_i) begin
                  gnt     = 1'b1;
                  ram_ce  = 1'b1;
                  ram_we  = we_i;
                  ram_a   = word_idx;
                  ram_d   = wdata_i;
                  ram_bwm = bwm_full[WIDTH-1:0];
               end
            end
            default: state_d = SERVE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= CLEAR_ON_RESET ? CLEAR : SERVE;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= gnt;
      end
   end

   assign gnt_o       = gnt;
   assign rvalid_o    = rvalid_q & ~RST;
   assign rdata_o     = ram_q;
   assign init_done_o = (state_q == SERVE);

endmodule

// File: tb/tb_spram_bus_ctrl.sv
// Scoreboard bench for spram_bus_ctrl with a behavioural byte-masked SRAM attached.
module tb_spram_bus_ctrl;

   localparam int DEPTH   = 16;
   localparam int WIDTH   = 32;
   localparam int DEPTH_W = $clog2(DEPTH);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req = 1'b0;
   logic               gnt;
   logic               we = 1'b0;
   logic [3:0]         be = 4'h0;
   logic [31:0]        addr = 32'h0;
   logic [WIDTH-1:0]   wdata = '0;
   logic               rvalid;
   logic [WIDTH-1:0]   rdata;
   logic               clear = 1'b0;
   logic               init_done;
   logic               ram_ce, ram_we;
   logic [WIDTH-1:0]   ram_bwm, ram_d;
   logic [DEPTH_W-1:0] ram_a;
   logic [WIDTH-1:0]   ram_q = '0;
   logic [WIDTH-1:0]   mem [DEPTH];

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spram_bus_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CLEAR_ON_RESET(1'b1)) dut (
      .CLK(clk), .RST(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
      .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
      .clear_i(clear), .init_done_o(init_done), .ram_ce(ram_ce), .ram_we(ram_we),
      .ram_bwm(ram_bwm), .ram_d(ram_d), .ram_a(ram_a), .ram_q(ram_q)
   );

   // Attached SRAM: Q updates only on reads and holds otherwise.
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_we) mem[ram_a] <= (mem[ram_a] & ~ram_bwm) | (ram_d & ram_bwm);
         else        ram_q <= mem[ram_a];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Monitor: pops one expectation per response the DUT presents.
   initial begin
      forever begin
         @(negedge clk);
         if (rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rvalid: got rvalid=1 expected no response");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (e.is_read && rdata !== e.data) begin
                  errors++;
                  $display("FAIL %s: rdata 0x%08h expected 0x%08h", e.name, rdata, e.data);
               end else begin
                  $display("ok   %s: response rdata=0x%08h", e.name, rdata);
               end
            end
         end
      end
   end

   // Called just after a posedge; returns just after the next posedge.
   task automatic access(input string name, input bit w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
      exp_t e;
      req = 1'b1; we = w; be = b; addr = a; wdata = d;
      @(negedge clk);
      check({name, "_gnt"}, {31'd0, gnt}, 32'd1);
      e.is_read = !w; e.data = exp_rd; e.name = name;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      req = 1'b0; we = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Counts clear cycles (init_done low) with a bound; ends just after a posedge.
   task automatic wait_clear(output int n);
      n = 0;
      while (n < 64) begin
         @(negedge clk);
         if (init_done) break;
         n++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_rvalid", {31'd0, rvalid}, 32'd0);
      check("reset_gnt", {31'd0, gnt}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("clear_first_a", {28'd0, ram_a}, 32'd0);
      check("clear_first_ctl", {29'd0, ram_ce, ram_we, init_done}, 32'b110);
      check("clear_first_d", ram_d, 32'h0);
      @(posedge clk); #1;
      wait_clear(n);
      check("post_reset_clear_len", n, 32'd15);

      // Whole array reads back zero after clear, back-to-back
      for (int i = 0; i < DEPTH; i++) access($sformatf("rd0_w%0d", i), 1'b0, 4'hF, 32'(i * 4), '0, 32'h0);
      idle(2);

      // Byte-masked writes
      access("wr_full", 1'b1, 4'b1111, 32'h8, 32'hAABBCCDD, '0);
      access("wr_mask", 1'b1, 4'b0101, 32'h8, 32'h11223344, '0);
      access("wr_be0", 1'b1, 4'b0000, 32'h8, 32'hFFFFFFFF, '0);
      access("rd_mask", 1'b0, 4'hF, 32'h8, '0, 32'hAA22CC44);
      idle(1);

      // Back-to-back reads in order
      access("wr_w0", 1'b1, 4'hF, 32'h0, 32'h01010101, '0);
      access("wr_w1", 1'b1, 4'hF, 32'h4, 32'h02020202, '0);
      idle(1);
      access("b2b_0", 1'b0, 4'hF, 32'h0, '0, 32'h01010101);
      access("b2b_4", 1'b0, 4'hF, 32'h4, '0, 32'h02020202);
      access("b2b_8", 1'b0, 4'hF, 32'h8, '0, 32'hAA22CC44);
      idle(1);

      // Aliasing above the word index and ignored offset bits
      access("wr_alias", 1'b1, 4'hF, 32'h44, 32'h5A5A5A5A, '0);
      access("rd_alias", 1'b0, 4'hF, 32'h4, '0, 32'h5A5A5A5A);
      access("rd_offset", 1'b0, 4'hF, 32'h7, '0, 32'h5A5A5A5A);

      // Clear colliding with a request; previous response still delivered
      req = 1'b1; we = 1'b0; addr = 32'h8; clear = 1'b1;
      @(negedge clk);
      check("clear_vs_req_gnt", {31'd0, gnt}, 32'd0);
      @(posedge clk); #1;
      req = 1'b0; clear = 1'b0;
      @(negedge clk);
      check("clear_init_done_fall", {31'd0, init_done}, 32'd0);
      wait_clear(n);
      check("req_clear_len", n + 1, 32'd16);
      access("rd_after_clear", 1'b0, 4'hF, 32'h8, '0, 32'h0);
      idle(1);

      // Reset at clear counter 7 restarts the clear
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      n = 0;
      while (n < 64) begin
         @(negedge clk);
         if (ram_a == 4'd7 && !init_done) break;
         n++;
      end
      check("reached_cnt7", n, 32'd7);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("restart_a", {28'd0, ram_a}, 32'd0);
      wait_clear(n);
      check("restart_clear_len", n + 1, 32'd16);

      // Reset right after a read grant suppresses its response
      access("wr_w2", 1'b1, 4'hF, 32'h8, 32'h12345678, '0);
      req = 1'b1; we = 1'b0; addr = 32'h8;
      @(negedge clk);
      check("rst_rd_gnt", {31'd0, gnt}, 32'd1);
      @(posedge clk); #1;
      req = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rst_rvalid_suppressed", {31'd0, rvalid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      wait_clear(n);
      check("final_clear_len", n, 32'd16);
      access("rd_final", 1'b0, 4'hF, 32'h8, '0, 32'h0);
      idle(3);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
